// File: rtl/fma_core_pkg.sv
// fma_core_pkg: widths, bias, OpCtrl encodings and stage bundles
// shared by the FMA front end (no ports).
package fma_core_pkg;
  localparam int NE = 11;
  localparam int NF = 52;
  localparam int FMALEN = 3 * NF + 6;
  localparam int BIAS = (1 << (NE - 1)) - 1;
  localparam int SCNTW = $clog2(FMALEN + 1);

  localparam logic [2:0] FMADD  = 3'b000;
  localparam logic [2:0] FMSUB  = 3'b001;
  localparam logic [2:0] FNMSUB = 3'b010;
  localparam logic [2:0] FNMADD = 3'b011;
  localparam logic [2:0] FMUL   = 3'b100;

  typedef struct packed {
    logic          xs;
    logic          ys;
    logic          zs;
    logic [NE-1:0] xe;
    logic [NE-1:0] ye;
    logic [NE-1:0] ze;
    logic [NF:0]   xm;
    logic [NF:0]   ym;
    logic [NF:0]   zm;
    logic          xzero;
    logic          yzero;
    logic          zzero;
    logic [2:0]    op;
  } fma_in_t;

  typedef struct packed {
    logic              asticky;
    logic [FMALEN-1:0] sm;
    logic              inv_a;
    logic              a_sign;
    logic              p_sign;
    logic              s_sign;
    logic [NE+1:0]     se;
    logic [SCNTW-1:0]  scnt;
  } fma_out_t;
endpackage

// File: rtl/fma_core_if.sv
// fma_core_if: unpacked X/Y/Z operands + OpCtrl in, sum fields out.
// master drives operands, slave (fma_core) drives the results.
interface fma_core_if;
  import fma_core_pkg::*;

  logic              Xs, Ys, Zs;
  logic [NE-1:0]     Xe, Ye, Ze;
  logic [NF:0]       Xm, Ym, Zm;
  logic              XZero, YZero, ZZero;
  logic [2:0]        OpCtrl;
  logic              ASticky;
  logic [FMALEN-1:0] Sm;
  logic              InvA, As, Ps, Ss;
  logic [NE+1:0]     Se;
  logic [SCNTW-1:0]  SCnt;

  modport master (
    output Xs, Ys, Zs, Xe, Ye, Ze, Xm, Ym, Zm,
    output XZero, YZero, ZZero, OpCtrl,
    input  ASticky, Sm, InvA, As, Ps, Ss, Se, SCnt
  );

  modport slave (
    input  Xs, Ys, Zs, Xe, Ye, Ze, Xm, Ym, Zm,
    input  XZero, YZero, ZZero, OpCtrl,
    output ASticky, Sm, InvA, As, Ps, Ss, Se, SCnt
  );
endinterface

// File: rtl/fma_align.sv
// fma_align: places Zm in the sum window relative to the product.
// in: pe, ze, zm, zero/mul flags; out: am, kill (KillProd), sticky.
module fma_align import fma_core_pkg::*; (
  input  logic [NE+1:0]     pe,
  input  logic [NE-1:0]     ze,
  input  logic [NF:0]       zm,
  input  logic              zzero,
  input  logic              pzero,
  input  logic              mul,
  output logic [FMALEN-1:0] am,
  output logic              kill,
  output logic              sticky
);
  localparam int AW = NE + 3;
  localparam int WW = 2 * FMALEN;

  logic [AW-1:0] acnt;
  logic [WW-1:0] wide;
  logic          no_z;
  logic          neg;
  logic          over;

  assign acnt = {pe[NE+1], pe} - {3'b0, ze}
              + AW'(NF + 3);
  assign no_z = zzero | mul;
  assign neg  = acnt[AW-1];
  assign over = ~neg & (acnt > AW'(FMALEN - 1));

  // upper half is the window, lower half catches shifted-out bits
  assign wide = {zm, (WW - NF - 1)'(0)}
             >> acnt[SCNTW-1:0];

  always_comb begin
    am     = '0;
    kill   = 1'b0;
    sticky = 1'b0;
    unique case (1'b1)
      no_z: ;
      ~no_z & neg: begin
        kill   = 1'b1;
        am     = {zm, (FMALEN - NF - 1)'(0)};
        sticky = ~pzero;
      end
      ~no_z & over: sticky = 1'b1;
      default: begin
        am     = wide[WW-1:FMALEN];
        sticky = |wide[FMALEN-1:0];
      end
    endcase
  end
endmodule

// File: rtl/fma_core.sv
// fma_core: registered FMA front end; clk, rst, io (fma_core_if.slave).
// FMA_INPUT_REG_EN adds a reset input register (latency 2, else 1).
module fma_core import fma_core_pkg::*; (
  input logic       clk,
  input logic       rst,
  fma_core_if.slave io
);
  fma_in_t           raw, opd;
  fma_out_t          d, q;
  logic [2*NF+1:0]   pm;
  logic [NE+1:0]     pe;
  logic [FMALEN-1:0] pw, am, sm;
  logic [SCNTW-1:0]  scnt;
  logic              mul, pzero, kill, asticky;
  logic              p_sign, a_sign, inv_a;
  logic              borrow, a_big, zero_res, s_sign;

  always_comb begin
    raw = '{xs: io.Xs, ys: io.Ys, zs: io.Zs,
            xe: io.Xe, ye: io.Ye, ze: io.Ze,
            xm: io.Xm, ym: io.Ym, zm: io.Zm,
            xzero: io.XZero, yzero: io.YZero,
            zzero: io.ZZero, op: io.OpCtrl};
  end

`ifdef FMA_INPUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) opd <= '0;
    else     opd <= raw;
  end
`else
  assign opd = raw;
`endif

  assign mul    = opd.op[2];
  assign p_sign = opd.xs ^ opd.ys
                ^ (opd.op[1] & ~opd.op[2]);
  assign a_sign = opd.zs ^ (opd.op[0] & ~opd.op[2]);
  assign inv_a  = a_sign ^ p_sign;
  assign pzero  = opd.xzero | opd.yzero;

  assign pm = pzero ? '0
            : {(NF+1)'(0), opd.xm} * {(NF+1)'(0), opd.ym};
  assign pe = {2'b0, opd.xe} + {2'b0, opd.ye}
            - (NE+2)'(BIAS);

  fma_align u_align (
    .pe     (pe),
    .ze     (opd.ze),
    .zm     (opd.zm),
    .zzero  (opd.zzero),
    .pzero  (pzero),
    .mul    (mul),
    .am     (am),
    .kill   (kill),
    .sticky (asticky)
  );

  assign pw = kill ? '0 : {(NF+2)'(0), pm, 2'b0};

  // sticky bits belong to the smaller term and borrow one ulp
  assign borrow = inv_a & asticky;
  assign a_big  = {am, borrow} > {pw, 1'b0};

  always_comb begin
    if (!inv_a)     sm = pw + am;
    else if (kill)  sm = am - FMALEN'(borrow);
    else if (a_big) sm = am - pw;
    else            sm = pw - am - FMALEN'(borrow);
  end

  assign zero_res = (sm == '0) & ~asticky;
  assign s_sign = ~inv_a ? p_sign
                : zero_res ? 1'b0
                : a_big ? a_sign : p_sign;

  // highest set bit wins; all-zero leaves FMALEN
  always_comb begin
    scnt = SCNTW'(FMALEN);
    for (int i = 0; i < FMALEN; i++)
      if (sm[i]) scnt = SCNTW'(FMALEN - 1 - i);
  end

  always_comb begin
    d         = '0;
    d.asticky = asticky;
    d.sm      = sm;
    d.inv_a   = inv_a;
    d.a_sign  = a_sign;
    d.p_sign  = p_sign;
    d.s_sign  = s_sign;
    d.se      = kill ? {2'b0, opd.ze}
              : pe + (NE+2)'(NF + 3);
    d.scnt    = scnt;
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

  assign io.ASticky = q.asticky;
  assign io.Sm      = q.sm;
  assign io.InvA    = q.inv_a;
  assign io.As      = q.a_sign;
  assign io.Ps      = q.p_sign;
  assign io.Ss      = q.s_sign;
  assign io.Se      = q.se;
  assign io.SCnt    = q.scnt;
endmodule

// File: tb/tb_fma_core.sv
// tb_fma_core: directed FMA vectors with an expected-result queue.
// X=5, Y=6, Z=7 base operands; boundaries, zero flags and reset.
module tb_fma_core;
  import fma_core_pkg::*;

`ifdef FMA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [NF:0] M125  = 53'h14000000000000;
  localparam logic [NF:0] M150  = 53'h18000000000000;
  localparam logic [NF:0] M175  = 53'h1C000000000000;
  localparam logic [NF:0] M1875 = 53'h1E000000000000;
  localparam logic [NE-1:0] E = 11'h401;

  typedef logic [FMALEN-1:0] w_t;

  typedef struct {
    string tag;
    int    issue;
    int    due;
    w_t    sm;
    int    se;
    int    scnt;
    logic  ss;
    logic  a_s;
    logic  ps;
    logic  st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fma_core_if io();

  fma_core dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  exp_t q[$];
  int   cyc = 0;
  int   last_rst = -1;
  logic rst_edge = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic w_t sh(input int v, input int s);
    w_t r;
    r = w_t'(v);
    return r << s;
  endfunction

  function automatic w_t zmw(input logic [NF:0] m);
    w_t r;
    r = w_t'(m);
    return r << 109;
  endfunction

  task automatic chk(input string tag,
                     input w_t obs, input w_t exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s observed=%h expected=%h",
               tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_all(input string t, input exp_t e);
    chk({t, "/sm"}, io.Sm, e.sm);
    chk({t, "/se"}, w_t'(io.Se), w_t'(e.se));
    chk({t, "/scnt"}, w_t'(io.SCnt), w_t'(e.scnt));
    chk({t, "/ss"}, w_t'(io.Ss), w_t'(e.ss));
    chk({t, "/as"}, w_t'(io.As), w_t'(e.a_s));
    chk({t, "/ps"}, w_t'(io.Ps), w_t'(e.ps));
    chk({t, "/inva"}, w_t'(io.InvA),
        w_t'(e.a_s ^ e.ps));
    chk({t, "/st"}, w_t'(io.ASticky), w_t'(e.st));
  endtask

  task automatic check_out();
    exp_t e;
    exp_t z;
    if (rst_edge) begin
      z.sm = '0; z.se = 0; z.scnt = 0;
      z.ss = 0; z.a_s = 0; z.ps = 0; z.st = 0;
      chk_all("rst", z);
      while (q.size() > 0 && q[0].due <= cyc)
        void'(q.pop_front());
    end else begin
      while (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (e.issue > last_rst) chk_all(e.tag, e);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    rst_edge = rst;
    if (rst) last_rst = cyc;
    #1;
    check_out();
  endtask

  task automatic opnd(input logic [NE-1:0] xe, ye, ze,
                      input logic [NF:0] zm,
                      input logic [2:0] opc);
    io.Xs = 0; io.Ys = 0; io.Zs = 0;
    io.Xe = xe; io.Ye = ye; io.Ze = ze;
    io.Xm = M125; io.Ym = M150; io.Zm = zm;
    io.XZero = 0; io.YZero = 0; io.ZZero = 0;
    io.OpCtrl = opc;
  endtask

  task automatic issue(input string tag, input w_t sm,
                       input int se, input int scnt,
                       input logic ss, a_s, ps, st);
    exp_t e;
    e.tag = tag; e.issue = cyc + 1; e.due = cyc + LAT;
    e.sm = sm; e.se = se; e.scnt = scnt;
    e.ss = ss; e.a_s = a_s; e.ps = ps; e.st = st;
    q.push_back(e);
  endtask

  initial begin
    opnd(E, E, E, M175, FMADD);
    cycle();
    cycle();
    rst = 0;

    opnd(E, E, E, M175, FMADD);
    issue("add", sh(37, 102), 1082, 54, 0, 0, 0, 0);
    cycle();
    opnd(E, E, E, M175, FMSUB);
    issue("sub", sh(23, 102), 1082, 55, 0, 1, 0, 0);
    cycle();
    opnd(E, E, E, M175, FNMSUB);
    issue("nsub", sh(23, 102), 1082, 55, 1, 0, 1, 0);
    cycle();
    opnd(E, E, E, M175, FNMADD);
    issue("nadd", sh(37, 102), 1082, 54, 1, 1, 1, 0);
    cycle();
    opnd(E, E, E, M175, FMUL);
    issue("mul", sh(30, 102), 1082, 55, 0, 0, 0, 0);
    cycle();
    opnd(E, E, E, M175, 3'b111);
    issue("mul7", sh(30, 102), 1082, 55, 0, 0, 0, 0);
    cycle();
    opnd(E, E, 11'h403, M1875, FMSUB);
    issue("cancel", '0, 1082, 162, 0, 1, 0, 0);
    cycle();
    opnd(E, E, 11'h404, M175, FMSUB);
    issue("zbig", sh(26, 102), 1082, 55, 1, 1, 0, 0);
    cycle();
    opnd(E, E, 11'd1, M175, FMADD);
    issue("far_z", sh(30, 102), 1082, 55, 0, 0, 0, 1);
    cycle();
    opnd(E, E, 11'd1, M175, FMSUB);
    issue("far_zsub", sh(30, 102) - w_t'(1),
          1082, 55, 0, 1, 0, 1);
    cycle();
    opnd(E, E, 11'd921, M175, FMADD);
    issue("a161", sh(30, 102) + w_t'(1),
          1082, 55, 0, 0, 0, 1);
    cycle();
    opnd(E, E, 11'd920, M175, FMADD);
    issue("a162", sh(30, 102), 1082, 55, 0, 0, 0, 1);
    cycle();
    opnd(11'h200, 11'h200, 11'h600, M175, FMADD);
    issue("kill", zmw(M175), 1536, 0, 0, 0, 0, 1);
    cycle();
    opnd(E, E, 11'd1082, M175, FMADD);
    issue("a0", zmw(M175) + sh(30, 102),
          1082, 0, 0, 0, 0, 0);
    cycle();
    opnd(E, E, 11'd1083, M175, FMADD);
    issue("am1", zmw(M175), 1083, 0, 0, 0, 0, 1);
    cycle();
    opnd(E, E, E, M175, FMADD);
    io.XZero = 1;
    issue("xzero", sh(7, 102), 1082, 57, 0, 0, 0, 0);
    cycle();
    opnd(E, E, E, M175, FMADD);
    io.ZZero = 1;
    issue("zzero", sh(30, 102), 1082, 55, 0, 0, 0, 0);
    cycle();
    opnd(E, E, E, M175, FMADD);
    io.Xs = 1;
    issue("xneg", sh(23, 102), 1082, 55, 1, 0, 1, 0);
    cycle();

    opnd(E, E, E, M175, FMADD);
    issue("pre", sh(37, 102), 1082, 54, 0, 0, 0, 0);
    cycle();
    rst = 1;
    opnd(E, E, E, M175, FMSUB);
    issue("lost", sh(23, 102), 1082, 55, 0, 1, 0, 0);
    cycle();
    cycle();
    rst = 0;
    opnd(E, E, E, M175, FMSUB);
    issue("post1", sh(23, 102), 1082, 55, 0, 1, 0, 0);
    cycle();
    opnd(E, E, E, M175, FNMADD);
    issue("post2", sh(37, 102), 1082, 54, 1, 1, 1, 0);
    cycle();
    for (int i = 0; i < LAT; i++) cycle();

    chk("drain", w_t'(q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
